// File: rtl/uart_dbg_parser_if.sv
// Byte-in / register-write-out link between the UART receiver, the debug
// packet parser and the debug register file write port.
interface uart_dbg_parser_if;
  logic [7:0]  rxdata;
  logic        rxvalid;
  logic        busy;
  logic [4:0]  dbgsel;
  logic [31:0] dbgin;
  logic        dbgwriteen;
  logic        pktdone;
  logic        pkterr;

  // Byte source side (UART receiver or bench)
  modport master (
    output rxdata, rxvalid,
    input  busy, dbgsel, dbgin, dbgwriteen, pktdone, pkterr
  );

  // Parser side
  modport slave (
    input  rxdata, rxvalid,
    output busy, dbgsel, dbgin, dbgwriteen, pktdone, pkterr
  );
endinterface

// File: rtl/uart_dbg_parser.sv
// Debug-dump packet parser: "P" then hex fields each ended by ',' then newline.
// Every completed field becomes one registered write strobe into the debug
// register file; framing errors pulse pkterr and discard to the next newline or 'P'.
module uart_dbg_parser #(
  parameter int unsigned NFIELDS  = 31,
  parameter logic [4:0]  FIRSTREG = 5'd1
) (
  input  logic             dbgclk,
  input  logic             rst,
  uart_dbg_parser_if.slave dbg
);

  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_CM = 8'h2C;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [5:0] NFLD_MAX = 6'(NFIELDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIELD,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  ndig_q, ndig_d;
  logic [5:0]  nfld_q, nfld_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] din_q, din_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        is_hex;
  logic [3:0]  nib;
  logic        start;
  logic        fail;
  logic        commit;
  logic        fld_full;

  // Hex digit decode of the incoming byte (upper and lower case letters)
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (dbg.rxdata >= 8'h30 && dbg.rxdata <= 8'h39) begin
      is_hex = 1'b1;
      nib    = dbg.rxdata[3:0];
    end else if ((dbg.rxdata >= 8'h41 && dbg.rxdata <= 8'h46) ||
                 (dbg.rxdata >= 8'h61 && dbg.rxdata <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = dbg.rxdata[3:0] + 4'd9;
    end
  end

  assign fld_full = (nfld_q >= NFLD_MAX);

  // Next-state and output decode; byte classification sets start/fail/commit
  // flags which are then applied once, so restart and error have one home each.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    nfld_d  = nfld_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    din_d   = din_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start   = 1'b0;
    fail    = 1'b0;
    commit  = 1'b0;

    if (dbg.rxvalid) begin
      unique case (state_q)
        S_IDLE: begin
          if (dbg.rxdata == CH_P) start = 1'b1;
        end
        S_FIELD: begin
          if (dbg.rxdata == CH_P) begin
            start = 1'b1;
          end else if (is_hex) begin
            if (ndig_q == 4'd8) begin
              fail = 1'b1;
            end else begin
              acc_d  = {acc_q[27:0], nib};
              ndig_d = ndig_q + 4'd1;
            end
          end else if (dbg.rxdata == CH_CM) begin
            if (ndig_q == 4'd0 || fld_full) fail   = 1'b1;
            else                            commit = 1'b1;
          end else if (dbg.rxdata == CH_LF) begin
            if (ndig_q != 4'd0 && fld_full) begin
              fail = 1'b1;
            end else begin
              commit  = (ndig_q != 4'd0);
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else if (dbg.rxdata != CH_CR) begin
            fail = 1'b1;
          end
        end
        S_DISCARD: begin
          if (dbg.rxdata == CH_P)       start   = 1'b1;
          else if (dbg.rxdata == CH_LF) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (commit) begin
      we_d   = 1'b1;
      sel_d  = idx_q;
      din_d  = acc_q;
      idx_d  = idx_q + 5'd1;
      nfld_d = nfld_q + 6'd1;
      acc_d  = '0;
      ndig_d = '0;
    end

    if (start) begin
      state_d = S_FIELD;
      busy_d  = 1'b1;
      acc_d   = '0;
      ndig_d  = '0;
      nfld_d  = '0;
      idx_d   = FIRSTREG;
    end

    if (fail) begin
      state_d = S_DISCARD;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge dbgclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ndig_q  <= '0;
      nfld_q  <= '0;
      idx_q   <= FIRSTREG;
      busy_q  <= 1'b0;
      sel_q   <= FIRSTREG;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      nfld_q  <= nfld_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dbg.busy       = busy_q;
  assign dbg.dbgsel     = sel_q;
  assign dbg.dbgin      = din_q;
  assign dbg.dbgwriteen = we_q;
  assign dbg.pktdone    = done_q;
  assign dbg.pkterr     = err_q;

endmodule
